// File: rtl/core_pkg.sv
// Shared core definitions used by the writeback path: load funct3 encodings,
// the buffered writeback entry, and a small register-index helper.
package core_pkg;

    localparam int CORE_XLEN = 32;
    localparam int NUM_REGS  = 32;

    // Load width/sign encodings carried in funct3; other codes behave as LW.
    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_funct3_e;

    // One buffered load result, already extended to register width.
    typedef struct packed {
        logic [4:0]           rd;
        logic [CORE_XLEN-1:0] data;
    } wb_entry_t;

    // One-hot register mask; x0 never produces a bit since it is hardwired zero.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [4:0] rd, input logic en);
        reg_onehot = '0;
        if (en && (rd != 5'd0)) begin
            reg_onehot[rd] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small circular buffer for load results. The head is visible combinationally
// so the writeback stage can pop and register it in the same edge. ready_o is
// a registered "not full" flag so the upstream handshake never sees a
// combinational path from this cycle's pop.
module wb_fifo #(
    parameter int  DEPTH   = 2,
    parameter type entry_t = logic [7:0]
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push_i,
    input  entry_t push_data_i,
    input  logic   pop_i,
    output entry_t head_o,
    output logic   empty_o,
    output logic   ready_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             ready_q;
    logic             do_push;
    logic             do_pop;

    // A push is only honoured while ready, so a full buffer is never overwritten.
    assign do_push = push_i && ready_q;
    assign do_pop  = pop_i && (count_q != '0);

    // Occupancy after this edge; drives both the count and the ready flag.
    always_comb begin
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; reset empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            ready_q <= (count_d != CNT_W'(DEPTH));
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign ready_o = ready_q;

endmodule

// File: rtl/writeback_unit.sv
// Register-file writeback arbiter. ALU results are written one cycle after
// they arrive and always win the write port; load returns are extended,
// buffered in wb_fifo and written whenever the ALU leaves the port free.
// A pending-load scoreboard answers decode's hazard query.
// The data width XLEN is expected to match core_pkg::CORE_XLEN, since the
// buffered entry type comes from the shared package.
module writeback_unit
    import core_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int XLEN       = 32
) (
    input  logic            clk,
    input  logic            rst,
    // ALU result, no backpressure
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    // Raw load return
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [4:0]      mem_rd,
    input  logic [2:0]      mem_funct3,
    input  logic [1:0]      mem_addr_lo,
    input  logic [XLEN-1:0] mem_rdata,
    // Load issue notification
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    // Hazard query
    input  logic [4:0]      q_rs1,
    input  logic [4:0]      q_rs2,
    output logic            stall,
    // Register-file write port
    output logic [4:0]      wsel,
    output logic [XLEN-1:0] wdata,
    output logic            wen
);

    // Select the addressed byte/half of the raw word and extend it to XLEN.
    function automatic logic [XLEN-1:0] extend_load(input logic [2:0]      f3,
                                                    input logic [1:0]      lo,
                                                    input logic [XLEN-1:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*lo +: 8];
        h = lo[1] ? w[16 +: 16] : w[0 +: 16];
        case (load_funct3_e'(f3))
            F3_LB:   extend_load = {{(XLEN-8){b[7]}}, b};
            F3_LH:   extend_load = {{(XLEN-16){h[15]}}, h};
            F3_LBU:  extend_load = {{(XLEN-8){1'b0}}, b};
            F3_LHU:  extend_load = {{(XLEN-16){1'b0}}, h};
            default: extend_load = w;
        endcase
    endfunction

    wb_entry_t            push_entry;
    wb_entry_t            head_entry;
    logic                 fifo_empty;
    logic                 fifo_ready;
    logic                 mem_accept;
    logic                 load_pop;

    logic                 wen_q;
    logic [4:0]           wsel_q;
    logic [XLEN-1:0]      wdata_q;

    logic [NUM_REGS-1:0]  pending_q;
    logic [NUM_REGS-1:0]  pending_d;
    logic [NUM_REGS-1:0]  set_mask;
    logic [NUM_REGS-1:0]  clr_mask;

    // Handshake: the buffer's registered ready doubles as mem_ready.
    assign mem_ready  = fifo_ready;
    assign mem_accept = mem_valid && fifo_ready;

    // The ALU owns the write port whenever it has a result.
    assign load_pop = !fifo_empty && !alu_valid;

    // Extension happens before buffering so the buffer holds final values.
    always_comb begin
        push_entry      = '0;
        push_entry.rd   = mem_rd;
        push_entry.data = extend_load(mem_funct3, mem_addr_lo, mem_rdata);
    end

    wb_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (wb_entry_t)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst),
        .push_i      (mem_accept),
        .push_data_i (push_entry),
        .pop_i       (load_pop),
        .head_o      (head_entry),
        .empty_o     (fifo_empty),
        .ready_o     (fifo_ready)
    );

    // Write-port register: ALU first, else a buffered load, else idle with
    // select/data held. Writes to x0 still consume their slot but keep wen low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wen_q   <= 1'b0;
            wsel_q  <= '0;
            wdata_q <= '0;
        end else if (alu_valid) begin
            wen_q   <= (alu_rd != 5'd0);
            wsel_q  <= alu_rd;
            wdata_q <= alu_data;
        end else if (load_pop) begin
            wen_q   <= (head_entry.rd != 5'd0);
            wsel_q  <= head_entry.rd;
            wdata_q <= head_entry.data;
        end else begin
            wen_q   <= 1'b0;
        end
    end

    assign wen   = wen_q;
    assign wsel  = wsel_q;
    assign wdata = wdata_q;

    // Scoreboard update: a popped load clears its bit, an issue sets one, and
    // a set on the same register in the same edge wins over the clear.
    always_comb begin
        set_mask  = reg_onehot(issue_rd, issue_valid);
        clr_mask  = reg_onehot(head_entry.rd, load_pop);
        pending_d = (pending_q & ~clr_mask) | set_mask;
    end

    // Pending-load bits; ALU writes never touch them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign stall = pending_q[q_rs1] | pending_q[q_rs2];

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios followed by random traffic.
// The driver computes expected register writes from a queue-based model and
// tags each with the cycle it must appear in; a separate monitor compares.
module tb_writeback_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [4:0]  mem_rd = '0;
    logic [2:0]  mem_funct3 = '0;
    logic [1:0]  mem_addr_lo = '0;
    logic [31:0] mem_rdata = '0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic [4:0]  q_rs1 = '0;
    logic [4:0]  q_rs2 = '0;
    logic        stall;
    logic [4:0]  wsel;
    logic [31:0] wdata;
    logic        wen;

    writeback_unit #(.FIFO_DEPTH(DEPTH), .XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_rd      (mem_rd),
        .mem_funct3  (mem_funct3),
        .mem_addr_lo (mem_addr_lo),
        .mem_rdata   (mem_rdata),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .q_rs1       (q_rs1),
        .q_rs2       (q_rs2),
        .stall       (stall),
        .wsel        (wsel),
        .wdata       (wdata),
        .wen         (wen)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc   = 0;
    wr_t exp_q[$];
    wr_t mdl_fifo[$];
    bit  pend[32];
    bit  armed = 1'b0;

    always @(posedge clk) cyc++;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endfunction

    // Load extension straight from the ISA rules, using shifts and masks.
    function automatic logic [31:0] ref_ext(input int f3, input int lo, input logic [31:0] w);
        logic [31:0] v;
        case (f3)
            0, 4: begin
                v = (w >> (8 * lo)) & 32'h0000_00FF;
                if (f3 == 0 && v >= 32'd128) v = v | 32'hFFFF_FF00;
            end
            1, 5: begin
                v = (w >> (16 * (lo / 2))) & 32'h0000_FFFF;
                if (f3 == 1 && v >= 32'd32768) v = v | 32'hFFFF_0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    // Monitor: each expected write carries the cycle it must appear in.
    always @(negedge clk) begin
        if (rst) begin
            if (exp_q.size() > 0 && exp_q[0].tag == cyc) begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wb_wen", wen, 1'b1);
                chk("wb_sel", wsel, e.rd);
                chk("wb_data", wdata, e.data);
                $display("write cycle %0d: x%0d <= 0x%08h", cyc, wsel, wdata);
            end else if (wen) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got wsel=%0d wdata=0x%0h, expected no write (cycle %0d)", wsel, wdata, cyc);
            end
        end
    end

    // One clock of stimulus: drive, check registered/comb outputs against the
    // model, advance the model across the coming edge, then step the clock.
    task automatic cycle(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                         input bit mv, input logic [4:0] mr, input logic [2:0] mf,
                         input logic [1:0] ml, input logic [31:0] mw,
                         input bit iv, input logic [4:0] ir,
                         input logic [4:0] q1, input logic [4:0] q2, output bit acc);
        bit  rdy;
        wr_t e;
        alu_valid = av; alu_rd = ar; alu_data = ad;
        mem_valid = mv; mem_rd = mr; mem_funct3 = mf; mem_addr_lo = ml; mem_rdata = mw;
        issue_valid = iv; issue_rd = ir; q_rs1 = q1; q_rs2 = q2;
        #1;
        rdy = armed && (mdl_fifo.size() < DEPTH);
        chk("mem_ready", mem_ready, rdy);
        chk("stall", stall, pend[q1] | pend[q2]);
        acc = mv && rdy;
        if (av) begin
            if (ar != 5'd0) begin
                e.tag = cyc + 1; e.rd = ar; e.data = ad;
                exp_q.push_back(e);
            end
        end else if (mdl_fifo.size() > 0) begin
            e = mdl_fifo.pop_front();
            pend[e.rd] = 1'b0;
            if (e.rd != 5'd0) begin
                e.tag = cyc + 1;
                exp_q.push_back(e);
            end
        end
        if (acc) begin
            e.tag = 0; e.rd = mr; e.data = ref_ext(int'(mf), int'(ml), mw);
            mdl_fifo.push_back(e);
        end
        if (iv && ir != 5'd0) pend[ir] = 1'b1;
        armed = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic [4:0] q1);
        bit a;
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, q1, 0, a);
    endtask

    task automatic load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                        input logic [31:0] w, input logic [4:0] q1, output bit acc);
        cycle(0, 0, 0, 1, rd, f3, lo, w, 0, 0, q1, 0, acc);
    endtask

    initial begin
        bit          a;
        int          n_acc;
        bit          ld_v;
        logic [4:0]  ld_rd;
        logic [2:0]  ld_f3;
        logic [1:0]  ld_lo;
        logic [31:0] ld_w;
        logic [31:0] ldw [3];

        // Reset state
        #12;
        chk("rst_wen", wen, 0);
        chk("rst_wsel", wsel, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_mem_ready", mem_ready, 0);
        chk("rst_stall", stall, 0);
        @(negedge clk);
        rst = 1'b1;
        armed = 1'b0;

        // ALU latency and idle hold
        cycle(1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 0, a);
        chk("alu_wen", wen, 1);
        chk("alu_wsel", wsel, 5);
        chk("alu_wdata", wdata, 32'h1234);
        idle(1, 0);
        chk("idle_wen", wen, 0);
        chk("idle_wsel_hold", wsel, 5);
        chk("idle_wdata_hold", wdata, 32'h1234);

        // Load extension examples
        load(3, 3'b000, 2'd3, 32'h80FF7F01, 0, a);
        idle(1, 0);
        chk("lb_wsel", wsel, 3);
        chk("lb_wdata", wdata, 32'hFFFFFF80);
        load(4, 3'b101, 2'd2, 32'h80FF7F01, 0, a);
        idle(1, 0);
        chk("lhu_wdata", wdata, 32'h000080FF);

        // ALU stream while three loads arrive; upstream holds what is refused
        ldw[0] = 32'h11111111; ldw[1] = 32'h22222222; ldw[2] = 32'h33333333;
        n_acc = 0;
        for (int i = 0; i < 4; i++) begin
            if (n_acc < 3) cycle(1, 5'(10 + i), 32'(100 + i), 1, 5'(20 + n_acc), 3'b010, 0, ldw[n_acc], 0, 0, 0, 0, a);
            else cycle(1, 5'(10 + i), 32'(100 + i), 0, 0, 0, 0, 0, 0, 0, 0, 0, a);
            if (a) n_acc++;
        end
        chk("accepted_under_alu", n_acc, 2);
        for (int i = 0; i < 8 && n_acc < 3; i++) begin
            load(5'(20 + n_acc), 3'b010, 0, ldw[n_acc], 0, a);
            if (a) n_acc++;
        end
        chk("all_loads_accepted", n_acc, 3);
        idle(3, 0);

        // Scoreboard: set, clear on pop, same-edge reissue
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0, a);
        chk("stall_rd7_set", stall, 1);
        load(7, 3'b010, 0, 32'hCAFE0007, 7, a);
        chk("stall_rd7_queued", stall, 1);
        idle(1, 7);
        chk("stall_rd7_cleared", stall, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0, a);
        load(7, 3'b010, 0, 32'hCAFE0017, 7, a);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0, a);
        chk("stall_rd7_reissue", stall, 1);
        load(7, 3'b010, 0, 32'hCAFE0027, 7, a);
        idle(1, 7);
        chk("stall_rd7_final", stall, 0);

        // x0 writes and ALU writes leave the scoreboard alone
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 9, 0, a);
        cycle(1, 9, 32'h99, 0, 0, 0, 0, 0, 0, 0, 9, 0, a);
        chk("alu_keeps_pending", stall, 1);
        cycle(1, 0, 32'hDEAD, 0, 0, 0, 0, 0, 0, 0, 9, 0, a);
        chk("alu_x0_wen", wen, 0);
        load(0, 3'b010, 0, 32'hBEEF, 9, a);
        idle(1, 9);
        chk("load_x0_wen", wen, 0);
        chk("x0_pending_kept", stall, 1);
        load(9, 3'b010, 0, 32'h9999, 9, a);
        idle(2, 9);

        // Reset mid-operation with two entries queued and bits pending
        cycle(1, 12, 32'h1, 1, 13, 3'b010, 0, 32'hAAAA, 1, 13, 13, 14, a);
        cycle(1, 14, 32'h2, 1, 14, 3'b010, 0, 32'hBBBB, 1, 14, 13, 14, a);
        rst = 1'b0;
        exp_q.delete();
        mdl_fifo.delete();
        for (int i = 0; i < 32; i++) pend[i] = 1'b0;
        #1;
        chk("midrst_wen", wen, 0);
        chk("midrst_wsel", wsel, 0);
        chk("midrst_wdata", wdata, 0);
        chk("midrst_mem_ready", mem_ready, 0);
        chk("midrst_stall", stall, 0);
        alu_valid = 0; mem_valid = 0; issue_valid = 0;
        @(negedge clk);
        rst = 1'b1;
        armed = 1'b0;
        idle(4, 13);

        // Random traffic
        ld_v = 0; ld_rd = 0; ld_f3 = 0; ld_lo = 0; ld_w = 0;
        for (int i = 0; i < 3000; i++) begin
            bit          av;
            bit          iv;
            logic [4:0]  ar;
            logic [4:0]  ir;
            if (!ld_v && $urandom_range(0, 9) < 5) begin
                ld_v  = 1;
                ld_rd = 5'($urandom_range(0, 7));
                ld_f3 = 3'($urandom_range(0, 7));
                ld_lo = 2'($urandom_range(0, 3));
                ld_w  = $urandom;
            end
            av = ($urandom_range(0, 9) < 4);
            ar = 5'($urandom_range(0, 31));
            iv = ($urandom_range(0, 9) < 3);
            ir = 5'($urandom_range(0, 7));
            cycle(av, ar, $urandom, ld_v, ld_rd, ld_f3, ld_lo, ld_w, iv, ir,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), a);
            if (a) ld_v = 0;
        end
        idle(DEPTH + 3, 0);
        @(negedge clk);
        #1;
        chk("writes_outstanding", exp_q.size(), 0);
        chk("model_fifo_left", mdl_fifo.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
